pipeline_stage_skid: RTL and testbench

PIPELINE_STAGE_SKID -- requirements
Module: pipeline_stage_skid

---
 rtl/pipeline_stage_skid.sv | 161 ++++++++++++++++
 tb/tb_pipeline_stage_skid.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_stage_skid.sv
// pipeline_stage_skid: two-entry elastic pipeline register (main + skid).
// The main register drives the outputs. The skid register absorbs one entry
// so that in_ready depends only on registered state, never on out_ready.
module pipeline_stage_skid #(
  parameter int                DATA_W  = 32,
  parameter int                ADDR_W  = 32,
  parameter logic [DATA_W-1:0] NOP     = DATA_W'(32'h0100_0000),
  parameter int                STALL_W = 16
) (
  input  logic               Clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  input  logic [ADDR_W-1:0]  in_pc,
  input  logic [ADDR_W-1:0]  in_npc,
  input  logic               annul,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic [ADDR_W-1:0]  out_pc,
  output logic [ADDR_W-1:0]  out_npc,
  output logic               out_annul,
  output logic [STALL_W-1:0] stall_cnt
);

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_BUSY  = 2'd1;
  localparam logic [1:0] S_FULL  = 2'd2;

  localparam logic [ADDR_W-1:0] PC_RST  = '0;
  localparam logic [ADDR_W-1:0] NPC_RST = ADDR_W'(4);

  logic [1:0]         r_state;
  logic [1:0]         w_state_next;

  logic [DATA_W-1:0]  r_main_data;
  logic [ADDR_W-1:0]  r_main_pc;
  logic [ADDR_W-1:0]  r_main_npc;
  logic               r_main_annul;
  logic [DATA_W-1:0]  r_skid_data;
  logic [ADDR_W-1:0]  r_skid_pc;
  logic [ADDR_W-1:0]  r_skid_npc;
  logic               r_skid_annul;
  logic [STALL_W-1:0] r_stall_cnt;

  logic               w_in_ready;
  logic               w_out_valid;
  logic               w_in_fire;
  logic               w_out_fire;
  logic               w_load_main_in;
  logic               w_load_main_skid;
  logic               w_load_skid;
  logic [DATA_W-1:0]  w_in_data_eff;

  assign w_in_fire     = in_valid & w_in_ready;
  assign w_out_fire    = w_out_valid & out_ready;
  // Annulled entries carry a nop payload; their pc/npc are kept for tracing.
  assign w_in_data_eff = annul ? NOP : in_data;

  // State register
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) r_state <= S_EMPTY;
    else       r_state <= w_state_next;
  end

  // Next-state logic; flush overrides every other event
  always_comb begin
    w_state_next = r_state;
    if (flush) begin
      w_state_next = S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: if (w_in_fire) w_state_next = S_BUSY;
        S_BUSY: begin
          if (w_in_fire && !w_out_fire)      w_state_next = S_FULL;
          else if (!w_in_fire && w_out_fire) w_state_next = S_EMPTY;
        end
        S_FULL:  if (w_out_fire) w_state_next = S_BUSY;
        default: w_state_next = S_EMPTY;
      endcase
    end
  end

  // Output decode: handshake flags from state only, register load strobes
  always_comb begin
    w_out_valid      = (r_state != S_EMPTY);
    w_in_ready       = (r_state != S_FULL);
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    if (!flush) begin
      w_load_main_in   = ((r_state == S_EMPTY) && w_in_fire) ||
                         ((r_state == S_BUSY) && w_in_fire && w_out_fire);
      w_load_skid      = (r_state == S_BUSY) && w_in_fire && !w_out_fire;
      w_load_main_skid = (r_state == S_FULL) && w_out_fire;
    end
  end

  // Main register: takes the incoming entry or is refilled from the skid
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      r_main_data  <= NOP;
      r_main_pc    <= PC_RST;
      r_main_npc   <= NPC_RST;
      r_main_annul <= 1'b0;
    end else if (flush) begin
      r_main_data  <= NOP;
      r_main_pc    <= PC_RST;
      r_main_npc   <= NPC_RST;
      r_main_annul <= 1'b0;
    end else if (w_load_main_in) begin
      r_main_data  <= w_in_data_eff;
      r_main_pc    <= in_pc;
      r_main_npc   <= in_npc;
      r_main_annul <= annul;
    end else if (w_load_main_skid) begin
      r_main_data  <= r_skid_data;
      r_main_pc    <= r_skid_pc;
      r_main_npc   <= r_skid_npc;
      r_main_annul <= r_skid_annul;
    end
  end

  // Skid register: holds the one entry accepted while the head is stalled
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      r_skid_data  <= NOP;
      r_skid_pc    <= PC_RST;
      r_skid_npc   <= NPC_RST;
      r_skid_annul <= 1'b0;
    end else if (flush) begin
      r_skid_data  <= NOP;
      r_skid_pc    <= PC_RST;
      r_skid_npc   <= NPC_RST;
      r_skid_annul <= 1'b0;
    end else if (w_load_skid) begin
      r_skid_data  <= w_in_data_eff;
      r_skid_pc    <= in_pc;
      r_skid_npc   <= in_npc;
      r_skid_annul <= annul;
    end
  end

  // Back-pressure counter, saturating, cleared by flush
  always_ff @(posedge Clk or posedge reset) begin
    if (reset)                                          r_stall_cnt <= '0;
    else if (flush)                                     r_stall_cnt <= '0;
    else if (w_out_valid && !out_ready && !(&r_stall_cnt)) r_stall_cnt <= r_stall_cnt + 1'b1;
  end

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign out_data  = w_out_valid ? r_main_data : NOP;
  assign out_annul = w_out_valid & r_main_annul;
  assign out_pc    = r_main_pc;
  assign out_npc   = r_main_npc;
  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipeline_stage_skid.sv
// Testbench for pipeline_stage_skid: directed scenarios plus a randomized
// run checked against a queue-based model of a two-deep FIFO.
module tb_pipeline_stage_skid;

  localparam logic [31:0] NOP_W = 32'h0100_0000;
  localparam int          SW    = 4;

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] pc;
    logic [31:0] npc;
    logic        annul;
  } entry_t;

  logic          Clk, reset;
  logic          in_valid, in_ready, annul, flush, out_valid, out_ready, out_annul;
  logic [31:0]   in_data, in_pc, in_npc, out_data, out_pc, out_npc;
  logic [SW-1:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  entry_t m_q[$];
  int     m_stall;

  pipeline_stage_skid #(.DATA_W(32), .ADDR_W(32), .NOP(NOP_W), .STALL_W(SW)) dut (
    .Clk(Clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_pc(in_pc), .in_npc(in_npc), .annul(annul), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_pc(out_pc), .out_npc(out_npc), .out_annul(out_annul),
    .stall_cnt(stall_cnt)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic [31:0] pc,
                       input logic [31:0] npc, input logic an, input logic fl,
                       input logic ordy);
    in_valid = v; in_data = d; in_pc = pc; in_npc = npc;
    annul = an; flush = fl; out_ready = ordy;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_q.delete();
    m_stall = 0;
  endtask

  task automatic test_reset();
    drive(0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (out_data !== NOP_W) begin errors++; $display("FAIL reset_out_data got %h want %h", out_data, NOP_W); end
    checks++; if (out_pc !== 32'd0 || out_npc !== 32'd4) begin errors++; $display("FAIL reset_pc_npc got %h/%h want 0/4", out_pc, out_npc); end
    checks++; if (out_annul !== 1'b0 || stall_cnt !== '0) begin errors++; $display("FAIL reset_annul_stall got %b/%0d want 0/0", out_annul, stall_cnt); end
    @(negedge Clk);
    reset = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_basic();
    do_reset();
    drive(1, 32'h8200_0001, 32'h100, 32'h104, 0, 0, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 1);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b want 1", out_valid); end
    checks++; if (out_data !== 32'h8200_0001 || out_pc !== 32'h100 || out_npc !== 32'h104)
      begin errors++; $display("FAIL basic_fields got %h/%h/%h want 82000001/100/104", out_data, out_pc, out_npc); end
    tick();
    checks++; if (out_valid !== 1'b0 || out_data !== NOP_W) begin errors++; $display("FAIL basic_drain got %b/%h want 0/%h", out_valid, out_data, NOP_W); end
    $display("test_basic done");
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_seq [3];
    exp_seq[0] = 32'hA000_000A; exp_seq[1] = 32'hB000_000B; exp_seq[2] = 32'hC000_000C;
    do_reset();
    drive(1, exp_seq[0], 32'h10, 32'h14, 0, 0, 0); tick();
    drive(1, exp_seq[1], 32'h14, 32'h18, 0, 0, 0); tick();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_full_in_ready got %b want 0", in_ready); end
    drive(1, exp_seq[2], 32'h18, 32'h1C, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (out_data !== exp_seq[0] || in_ready !== 1'b0)
        begin errors++; $display("FAIL b2b_hold got %h/%b want %h/0", out_data, in_ready, exp_seq[0]); end
    end
    checks++; if (stall_cnt !== 4'd4) begin errors++; $display("FAIL b2b_stall got %0d want 4", stall_cnt); end
    out_ready = 1'b1;
    for (int i = 1; i < 3; i++) begin
      tick();
      checks++; if (out_valid !== 1'b1 || out_data !== exp_seq[i])
        begin errors++; $display("FAIL b2b_order[%0d] got %b/%h want 1/%h", i, out_valid, out_data, exp_seq[i]); end
      if (i == 1) checks++;
      if (i == 1 && in_ready !== 1'b1) begin errors++; $display("FAIL b2b_reopen got %b want 1", in_ready); end
    end
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty got %b want 0", out_valid); end
    $display("test_back_to_back done");
  endtask

  task automatic test_annul();
    do_reset();
    drive(1, 32'h9DE3_BFA0, 32'h200, 32'h204, 1, 0, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 1);
    checks++; if (out_data !== NOP_W || out_annul !== 1'b1 || out_pc !== 32'h200 || out_npc !== 32'h204)
      begin errors++; $display("FAIL annul got %h/%b/%h/%h want %h/1/200/204", out_data, out_annul, out_pc, out_npc, NOP_W); end
    tick();
    checks++; if (out_annul !== 1'b0) begin errors++; $display("FAIL annul_empty got %b want 0", out_annul); end
    $display("test_annul done");
  endtask

  task automatic test_flush_full();
    do_reset();
    drive(1, 32'h1111_1111, 32'h40, 32'h44, 0, 0, 0); tick();
    drive(1, 32'h2222_2222, 32'h44, 32'h48, 0, 0, 0); tick();
    drive(1, 32'h3333_3333, 32'h48, 32'h4C, 0, 1, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 1);
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || stall_cnt !== '0)
      begin errors++; $display("FAIL flush got v=%b r=%b s=%0d want 0/1/0", out_valid, in_ready, stall_cnt); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_leak got %b/%h want 0", out_valid, out_data); end
    end
    $display("test_flush_full done");
  endtask

  task automatic test_stall_saturate();
    do_reset();
    drive(1, 32'h5555_5555, 32'h80, 32'h84, 0, 0, 0); tick();
    in_valid = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 10) begin
        checks++; if (stall_cnt !== 4'd10) begin errors++; $display("FAIL stall_mid got %0d want 10", stall_cnt); end
      end
    end
    checks++; if (stall_cnt !== 4'd15) begin errors++; $display("FAIL stall_sat got %0d want 15", stall_cnt); end
    checks++; if (out_data !== 32'h5555_5555) begin errors++; $display("FAIL stall_stable got %h want 55555555", out_data); end
    $display("test_stall_saturate done");
  endtask

  task automatic test_async_reset();
    do_reset();
    drive(1, 32'h7777_7777, 32'h300, 32'h304, 0, 0, 0); tick();
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      begin errors++; $display("FAIL async_flags got %b/%b want 0/1", out_valid, in_ready); end
    checks++; if (out_data !== NOP_W || out_pc !== 32'd0 || out_npc !== 32'd4 || out_annul !== 1'b0 || stall_cnt !== '0)
      begin errors++; $display("FAIL async_fields got %h/%h/%h/%b/%0d want %h/0/4/0/0", out_data, out_pc, out_npc, out_annul, stall_cnt, NOP_W); end
    @(negedge Clk);
    reset = 1'b0;
    m_q.delete(); m_stall = 0;
    drive(1, 32'h8888_8888, 32'h400, 32'h404, 0, 0, 1); tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_data !== 32'h8888_8888)
      begin errors++; $display("FAIL async_first_accept got %b/%h want 1/88888888", out_valid, out_data); end
    tick();
    $display("test_async_reset done");
  endtask

  task automatic test_random();
    entry_t e, h;
    logic   v, an, fl, ordy, rdy;
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      // Compare current outputs with the model
      checks++; if (out_valid !== (m_q.size() > 0) || in_ready !== (m_q.size() < 2))
        begin errors++; $display("FAIL rand_flags cyc=%0d got %b/%b want %b/%b", cyc, out_valid, in_ready, m_q.size() > 0, m_q.size() < 2); end
      checks++; if (stall_cnt !== SW'(m_stall))
        begin errors++; $display("FAIL rand_stall cyc=%0d got %0d want %0d", cyc, stall_cnt, m_stall); end
      if (m_q.size() > 0) begin
        h = m_q[0];
        checks++; if (out_data !== h.data || out_pc !== h.pc || out_npc !== h.npc || out_annul !== h.annul)
          begin errors++; $display("FAIL rand_head cyc=%0d got %h/%h/%h/%b want %h/%h/%h/%b", cyc, out_data, out_pc, out_npc, out_annul, h.data, h.pc, h.npc, h.annul); end
      end else begin
        checks++; if (out_data !== NOP_W || out_annul !== 1'b0)
          begin errors++; $display("FAIL rand_empty cyc=%0d got %h/%b want %h/0", cyc, out_data, out_annul, NOP_W); end
      end
      // New stimulus
      v    = ($urandom_range(0, 3) != 0);
      an   = ($urandom_range(0, 5) == 0);
      fl   = ($urandom_range(0, 24) == 0);
      ordy = ($urandom_range(0, 2) != 0);
      e.data  = $urandom; e.pc = $urandom; e.npc = e.pc + 32'd4; e.annul = an;
      drive(v, e.data, e.pc, e.npc, an, fl, ordy);
      if (an) e.data = NOP_W;
      // Model update: two-deep FIFO, flush wins, saturating stall count
      rdy = (m_q.size() < 2);
      if (fl) begin
        m_q.delete();
        m_stall = 0;
      end else begin
        if (m_q.size() > 0 && !ordy && m_stall < (1 << SW) - 1) m_stall++;
        if (m_q.size() > 0 && ordy) begin
          h = m_q.pop_front();
          $display("xfer cyc=%0d data=%h pc=%h annul=%b", cyc, h.data, h.pc, h.annul);
        end
        if (v && rdy) m_q.push_back(e);
      end
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    $display("test_random done");
  endtask

  initial begin
    reset = 1'b0;
    m_stall = 0;
    drive(0, 0, 0, 0, 0, 0, 0);
    test_reset();
    test_basic();
    test_back_to_back();
    test_annul();
    test_flush_full();
    test_stall_saturate();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
